// File: rtl/map_probe_scheduler_pkg.sv
// Shared pacman definitions: direction bit positions, wall pixel code,
// probe offsets, scheduler state encoding and probe-table helpers.
package pacman_pkg;

  localparam logic [1:0] DIR_L = 2'd3;
  localparam logic [1:0] DIR_U = 2'd2;
  localparam logic [1:0] DIR_R = 2'd1;
  localparam logic [1:0] DIR_D = 2'd0;

  localparam logic [1:0] PIX_WALL = 2'b00;

  localparam int PROBE_NEAR = 12;
  localparam int PROBE_FAR  = 13;
  localparam int PROBE_ADJ  = 11;
  localparam int N_LOOKUP   = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LATCH,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Lookups come in groups of three: L, U, R, D.
  function automatic logic [1:0] dir_bit(input logic [5:0] k);
    if (k < 6'd3)      return DIR_L;
    else if (k < 6'd6) return DIR_U;
    else if (k < 6'd9) return DIR_R;
    else               return DIR_D;
  endfunction

  function automatic int probe_dx(input int k, input int near, input int far, input int adj);
    case (k)
      0, 4, 10: return -far;
      1, 2:     return -adj;
      5, 6, 11: return near;
      7, 8:     return adj;
      default:  return 0;
    endcase
  endfunction

  function automatic int probe_dy(input int k, input int near, input int far, input int adj);
    case (k)
      1, 3, 7:  return -far;
      2, 8, 9:  return near;
      4, 5:     return -adj;
      10, 11:   return adj;
      default:  return 0;
    endcase
  endfunction

endpackage

// File: rtl/map_probe_scheduler_if.sv
// Mover-side request/flag bus plus the shared mapRom query port.
interface map_probe_scheduler_if #(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 9
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ*COORD_W-1:0] pos_x;
  logic [N_REQ*COORD_W-1:0] pos_y;
  logic [COORD_W-1:0]       rom_x;
  logic [COORD_W-1:0]       rom_y;
  logic [1:0]               rom_pixel;
  logic [4*N_REQ-1:0]       flags;
  logic [N_REQ-1:0]         flags_valid;
  logic [N_REQ-1:0]         done;
  logic                     busy;

  modport master (
    output req, pos_x, pos_y, rom_pixel,
    input  rom_x, rom_y, flags, flags_valid, done, busy
  );

  modport slave (
    input  req, pos_x, pos_y, rom_pixel,
    output rom_x, rom_y, flags, flags_valid, done, busy
  );
endinterface

// File: rtl/map_probe_scheduler_rr_arbiter.sv
// Round-robin pick over N requesters; pointer moves past the winner on advance.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     pending,
  input  logic             advance,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  logic [IDX_W-1:0] ptr;

  always_comb begin
    gnt_idx = '0;
    gnt_any = 1'b0;
    for (int o = 0; o < N; o++) begin
      if (!gnt_any && pending[(int'(ptr) + o) % N]) begin
        gnt_idx = IDX_W'((int'(ptr) + o) % N);
        gnt_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ptr <= '0;
    else if (advance && gnt_any)
      ptr <= (gnt_idx == IDX_W'(N - 1)) ? '0 : gnt_idx + 1'b1;
  end

endmodule

// File: rtl/map_probe_scheduler.sv
// Time-shares one mapRom query port across all movers, running the 12-lookup
// wall probe per request and returning per-mover {L,U,R,D} passability.
module map_probe_scheduler
  import pacman_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int COORD_W = 9,
  parameter int NEAR    = PROBE_NEAR,
  parameter int FAR     = PROBE_FAR,
  parameter int ADJ     = PROBE_ADJ,
  parameter int ROM_LAT = 0
) (
  input logic                 clk,
  input logic                 reset,
  map_probe_scheduler_if.slave bus
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [5:0] LAT_C      = 6'(ROM_LAT);
  localparam logic [5:0] LAST_ISSUE = 6'(N_LOOKUP - 1);
  localparam logic [5:0] LAST_CNT   = 6'(N_LOOKUP - 1 + ROM_LAT);

  state_t               state;
  logic [N_REQ-1:0]     pending, gmask;
  logic [IDX_W-1:0]     gnt_idx, owner;
  logic                 gnt_any;
  logic [COORD_W-1:0]   lx, ly, cur_x, cur_y, rom_x, rom_y;
  logic [5:0]           cnt, samp_k;
  logic [3:0]           acc, acc_next;
  logic                 sampling;
  logic [4*N_REQ-1:0]   flags;
  logic [N_REQ-1:0]     flags_valid, done;

  function automatic logic [2*COORD_W-1:0] probe_addr(input int k,
      input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return {x + COORD_W'(probe_dx(k, NEAR, FAR, ADJ)),
            y + COORD_W'(probe_dy(k, NEAR, FAR, ADJ))};
  endfunction

  rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .pending (pending),
    .advance (state == ST_LATCH),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign cur_x = bus.pos_x[int'(gnt_idx)*COORD_W +: COORD_W];
  assign cur_y = bus.pos_y[int'(gnt_idx)*COORD_W +: COORD_W];
  assign gmask = (state == ST_LATCH && gnt_any) ? (N_REQ'(1) << gnt_idx) : '0;

  // Pixel for lookup k arrives ROM_LAT cycles after its address is issued.
  assign sampling = (state == ST_ISSUE || state == ST_DRAIN) && (cnt >= LAT_C);
  assign samp_k   = cnt - LAT_C;

  always_comb begin
    acc_next = acc;
    if (sampling && bus.rom_pixel == PIX_WALL) acc_next[dir_bit(samp_k)] = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      pending     <= '0;
      owner       <= '0;
      lx          <= '0;
      ly          <= '0;
      rom_x       <= '0;
      rom_y       <= '0;
      cnt         <= '0;
      acc         <= '0;
      flags       <= '0;
      flags_valid <= '0;
      done        <= '0;
    end else begin
      done    <= '0;
      // Set after clear so a pulse during the grant cycle queues another job.
      pending <= (pending & ~gmask) | bus.req;
      case (state)
        ST_IDLE: if (|pending) state <= ST_LATCH;
        ST_LATCH: begin
          owner          <= gnt_idx;
          lx             <= cur_x;
          ly             <= cur_y;
          {rom_x, rom_y} <= probe_addr(0, cur_x, cur_y);
          cnt            <= '0;
          acc            <= 4'hF;
          state          <= ST_ISSUE;
        end
        ST_ISSUE, ST_DRAIN: begin
          cnt <= cnt + 6'd1;
          acc <= acc_next;
          if (state == ST_ISSUE && cnt != LAST_ISSUE)
            {rom_x, rom_y} <= probe_addr(int'(cnt) + 1, lx, ly);
          if (cnt == LAST_CNT) begin
            for (int i = 0; i < N_REQ; i++) begin
              if (owner == IDX_W'(i)) begin
                flags[i*4 +: 4] <= acc_next;
                flags_valid[i]  <= 1'b1;
                done[i]         <= 1'b1;
              end
            end
            state <= ST_DONE;
          end else if (cnt == LAST_ISSUE) begin
            state <= ST_DRAIN;
          end
        end
        ST_DONE: state <= (|pending) ? ST_LATCH : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.rom_x       = rom_x;
  assign bus.rom_y       = rom_y;
  assign bus.flags       = flags;
  assign bus.flags_valid = flags_valid;
  assign bus.done        = done;
  assign bus.busy        = (state != ST_IDLE);

endmodule

// File: doc/map_probe_scheduler.md
Name: map_probe_scheduler

Overview:
Time-shares one combinational mapRom query port among all movers (pacman plus three monsters). On request, it runs the 12-lookup wall probe that decides which of L/U/R/D each mover may enter. Per-mover 4-bit passability flags are returned to the pacman/monster FSMs. This replaces one mapRom instance per probe point and sits between the movers and a single mapRom in graphic.

Parameters:
N_REQ, 4, number of requesters (index 0 = pacman, 1..3 = monsters)
COORD_W, 9, map coordinate width; all address arithmetic is modulo 2^COORD_W
NEAR, 12, offset to the right/down probe edge
FAR, 13, offset to the left/up probe edge
ADJ, 11, lateral shift for the side probes
ROM_LAT, 0, cycles from rom_x/rom_y valid to rom_pixel valid

Ports:
clk  in  1  system clock (50 MHz)
reset  in  1  asynchronous, active-low reset
req  in  N_REQ  one-cycle request pulse per mover
pos_x  in  N_REQ*COORD_W  packed mover x positions (requester i at [i*COORD_W +: COORD_W])
pos_y  in  N_REQ*COORD_W  packed mover y positions
rom_x  out  COORD_W  registered map query x
rom_y  out  COORD_W  registered map query y
rom_pixel  in  2  map pixel at (rom_x, rom_y); 2'b00 = wall
flags  out  4*N_REQ  per-requester {L,U,R,D}; 1 = passable
flags_valid  out  N_REQ  set at requester's first done, sticky
done  out  N_REQ  one-cycle pulse when requester's flags update
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, active low): state IDLE, all outputs 0, pending 0, round-robin pointer 0; an in-flight job is abandoned with no done pulse.
- pending[i] is set on req[i] and cleared on grant of i. A req[i] pulse while i is in service sets pending[i] again, so i runs one more job. Duplicate pulses while already pending merge into one job.
- Arbitration: round-robin. Search starts at the index after the last granted requester and wraps; after reset the search starts at 0.
- States:
  - IDLE: if any pending, go to LATCH.
  - LATCH: grant, capture pos_x/pos_y of the winner.
  - ISSUE: k = 0..11, one lookup per cycle.
  - DRAIN: ROM_LAT cycles; skipped when ROM_LAT = 0.
  - DONE: write flags, pulse done.
  - Exit from DONE: go to LATCH if anything is pending, else IDLE.
- Timing, grant in cycle 0:
  - lookup k is on rom_x/rom_y in cycle k+1;
  - rom_pixel for lookup k is sampled in cycle k+1+ROM_LAT;
  - done is asserted in cycle 13+ROM_LAT;
  - back-to-back job period is 14+ROM_LAT cycles.
- Lookup order (x,y), with X,Y the latched position:
  - L: (X-FAR, Y), (X-ADJ, Y-FAR), (X-ADJ, Y+NEAR)
  - U: (X, Y-FAR), (X-FAR, Y-ADJ), (X+NEAR, Y-ADJ)
  - R: (X+NEAR, Y), (X+ADJ, Y-FAR), (X+ADJ, Y+NEAR)
  - D: (X, Y+NEAR), (X-FAR, Y+ADJ), (X+NEAR, Y+ADJ)
- Direction flag = AND over its three lookups of (rom_pixel != 2'b00). Accumulate into a 4-bit shadow register; only the served requester's flags field is written, and only at DONE.
- flags are stable between done pulses. A mover's position changing during its job has no effect, because the position is latched in LATCH.
- Address arithmetic wraps modulo 2^COORD_W with no saturation (e.g. X=5, FAR=13 gives 504).
- rom_x/rom_y hold their last value outside ISSUE/DRAIN.

Decomposition:
- Shared package pacman_pkg holds:
  - direction bit positions L=3, U=2, R=1, D=0 (matching the L/U/R/D one-hot used by pacman);
  - PIX_WALL = 2'b00;
  - probe offsets NEAR/FAR/ADJ;
  - state encoding.
- One sub-module, rr_arbiter: N_REQ-wide round-robin pick with an advance-on-grant pointer. It is combinational pick plus a pointer register.

Test Plan:
- ROM model returns 2'b01 everywhere; req[0] pulse with pos (100,100) -> rom sequence starts (87,100); done[0] in cycle 13; flags[3:0]=4'b1111; flags_valid[0]=1.
- Wall (2'b00) only at (87,100); req[1] with pos (100,100) -> flags[7:4]=4'b0111. Wall only at (112,111) -> flags[7:4]=4'b1110.
- req=4'b1111 in one cycle -> done[0], done[1], done[2], done[3] at cycles 13, 27, 41, 55; busy stays high throughout.
- req[0] pulsed every job with req[2] held pending -> grants alternate 0,2,0,2; neither starves.
- req[3] with pos (5,3) -> first address (504,3); second address (506,502); flags computed normally.
- reset low in ISSUE cycle 6 -> all outputs 0 immediately; no done pulse. After release, req[2] -> fresh job, done[2] 13 cycles after grant. ROM_LAT=1 rerun -> done in cycle 14.
